// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame controller.
// Oversamples the synchronized RX line and qualifies the start bit with a
// 2-of-3 majority vote around mid-bit, which rejects short glitches. It then
// collects DATA_WIDTH data bits (LSB first), an optional parity bit and the
// stop bit. The byte is presented with a one-cycle DATA_VALID strobe, or a
// PAR_ERR / STP_ERR strobe is raised instead.
// Optional feature macro: UART_RX_ERR_CNT_EN adds the saturating ERR_CNT
// output, which counts errored frames and rejected start glitches.
// The controller returns to IDLE at the stop-bit decision point rather than
// at the end of the stop bit, so a new start edge is accepted half a stop
// bit early.

module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            ERR_CNT
`endif
);

    // The bit counter must reach 1 (start) + DATA_WIDTH + 1 (parity).
    localparam int BIT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q,      state_d;
    logic [PRESCALE_W-1:0]   edge_q,       edge_d;
    logic [BIT_W-1:0]        bit_q,        bit_d;
    logic [PRESCALE_W-1:0]   prescale_q,   prescale_d;
    logic                    par_en_q,     par_en_d;
    logic                    par_typ_q,    par_typ_d;
    logic [1:0]              samp_q,       samp_d;
    logic [DATA_WIDTH-1:0]   shift_q,      shift_d;
    logic                    par_flag_q,   par_flag_d;
    logic [DATA_WIDTH-1:0]   p_data_q,     p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q,    par_err_d;
    logic                    stp_err_q,    stp_err_d;
    logic                    busy_q,       busy_d;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]              err_cnt_q,    err_cnt_d;
    logic                    err_inc;
`endif

    // Decoded per-bit timing, all relative to the latched prescale.
    logic [PRESCALE_W-1:0]   half;
    logic                    at_wrap;
    logic [2:0]              tap_hit;
    logic                    at_decision;
    logic                    maj;
    logic                    par_exp;

    assign half    = prescale_q >> 1;
    assign at_wrap = (edge_q == prescale_q - PRESCALE_W'(1));

    // Three sample taps at P/2-1, P/2 and P/2+1; the last one is the decision point.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
        assign tap_hit[gi] = (state_q != S_IDLE) &&
                             (edge_q == half + PRESCALE_W'(gi) - PRESCALE_W'(1));
    end

    assign at_decision = tap_hit[2];

    // The third vote is the live line value in the decision cycle.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);

    assign par_exp = par_typ_q ? ~(^shift_q) : (^shift_q);

    // Next-state, counters, sampling and registered-output logic.
    always_comb begin
        state_d      = state_q;
        edge_d       = edge_q;
        bit_d        = bit_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_flag_d   = par_flag_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
        err_inc      = 1'b0;
`endif

        // Bit-period timebase shared by every non-idle state.
        if (state_q != S_IDLE) begin
            if (at_wrap) begin
                edge_d = '0;
                bit_d  = bit_q + BIT_W'(1);
            end else begin
                edge_d = edge_q + PRESCALE_W'(1);
            end
        end

        if (tap_hit[0]) begin
            samp_d[0] = RX_IN;
        end
        if (tap_hit[1]) begin
            samp_d[1] = RX_IN;
        end

        case (state_q)
            S_IDLE: begin
                edge_d     = '0;
                bit_d      = '0;
                par_flag_d = 1'b0;
                // Frame format is frozen for the whole frame once we leave IDLE.
                prescale_d = PRESCALE;
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                if (!RX_IN) begin
                    // The detection cycle counts as edge 0.
                    state_d = S_START;
                    edge_d  = PRESCALE_W'(1);
                end
            end

            S_START: begin
                if (at_decision && maj) begin
                    // Line came back high by mid-bit: a glitch, not a start bit.
                    state_d = S_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
`ifdef UART_RX_ERR_CNT_EN
                    err_inc = 1'b1;
`endif
                end else if (at_wrap) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (at_decision) begin
                    shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
                end
                // bit_q is 1 during data bit 0, so DATA_WIDTH marks the last bit.
                if (at_wrap && (bit_q == LAST_DATA_BIT)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end

            S_PARITY: begin
                if (at_decision && (maj != par_exp)) begin
                    par_flag_d = 1'b1;
                end
                if (at_wrap) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (at_decision) begin
                    state_d   = S_IDLE;
                    edge_d    = '0;
                    bit_d     = '0;
                    stp_err_d = ~maj;
                    par_err_d = par_flag_q;
                    if (maj && !par_flag_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
`ifdef UART_RX_ERR_CNT_EN
                    err_inc = ~maj | par_flag_q;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);

`ifdef UART_RX_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_flag_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_flag_q   <= par_flag_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // Saturating error counter, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`endif

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Testbench for uart_rx_frame_ctrl: directed frames with hand-computed
// expected strobe cycles, kinds and P_DATA values pushed to a scoreboard;
// a monitor pops and compares whenever any output strobe is seen.

module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       BUSY;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    uart_rx_frame_ctrl #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .BUSY       (BUSY)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .ERR_CNT    (err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Cycle index: value c during the interval following the c-th rising edge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [2:0] mask;   // {STP_ERR, PAR_ERR, DATA_VALID}
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] model_pdata = 8'h00;
    int         vec_cnt = 0;
    int         miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one frame starting in the current cycle (the detection cycle).
    // Returns with the line high, in the cycle after the stop bit ends.
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_bit, input logic stop_bit, input int stop_len,
                              input logic [2:0] mask, input bit expect_it);
        int   n;
        exp_t e;
        n = 1 + 8 + (par_en ? 1 : 0);
        if (expect_it) begin
            e.cycle = cyc + n * p + p / 2 + 2;
            e.mask  = mask;
            if (mask == 3'b001) model_pdata = data;
            e.data  = model_pdata;
            sb_q.push_back(e);
        end
        RX_IN = 1'b0;
        repeat (p) step();
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (p) step();
        end
        if (par_en) begin
            RX_IN = par_bit;
            repeat (p) step();
        end
        RX_IN = stop_bit;
        repeat (stop_len) step();
        RX_IN = 1'b1;
    endtask

    // Monitor: every strobe cycle must match the next scoreboard entry.
    always @(negedge CLK) begin
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, STP_ERR, PAR_ERR, DATA_VALID}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_cycle", cyc, mon_e.cycle);
                check("strobe_kind", {29'd0, STP_ERR, PAR_ERR, DATA_VALID}, {29'd0, mon_e.mask});
                check("p_data", {24'd0, P_DATA}, {24'd0, mon_e.data});
                $display("strobe at cycle %0d kind %b p_data 0x%02h", cyc,
                         {STP_ERR, PAR_ERR, DATA_VALID}, P_DATA);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;

        // Reset state
        RST = 1'b0;
        repeat (3) step();
        check("rst_p_data", {24'd0, P_DATA}, 32'd0);
        check("rst_valid", {31'd0, DATA_VALID}, 32'd0);
        check("rst_par_err", {31'd0, PAR_ERR}, 32'd0);
        check("rst_stp_err", {31'd0, STP_ERR}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        RST = 1'b1;
        repeat (2) step();

        // P=8, no parity, 0xA5: valid at 78
        PRESCALE = 6'd8; PAR_EN = 1'b0; step();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 8, 3'b001, 1'b1);
        repeat (4) step();

        // P=16, even parity, 0x3C with parity bit 1: PAR_ERR at 170, P_DATA held
        PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0; step();
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 16, 3'b010, 1'b1);
        repeat (4) step();

        // P=8, 0xFF with stop bit 0: STP_ERR at 78. Line released as IDLE resumes.
        PRESCALE = 6'd8; PAR_EN = 1'b0; step();
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 6, 3'b100, 1'b1);
        repeat (4) step();

        // Start glitch: low for 3 cycles, IDLE again at cycle 6
        t0 = cyc;
        RX_IN = 1'b0;
        repeat (3) step();
        RX_IN = 1'b1;
        repeat (2) step();
        check("glitch_busy_c5", {31'd0, BUSY}, 32'd1);
        step();
        check("glitch_busy_c6", {31'd0, BUSY}, 32'd0);
        check("glitch_cycle", cyc - t0, 32'd6);
        repeat (10) step();
`ifdef UART_RX_ERR_CNT_EN
        check("err_cnt_3", {24'd0, err_cnt}, 32'd3);
`endif

        // PRESCALE changed mid-frame: this frame still at P=8, next at P=16
        fork
            send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 8, 3'b001, 1'b1);
            begin
                repeat (20) step();
                PRESCALE = 6'd16;
            end
        join
        repeat (4) step();
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, 16, 3'b001, 1'b1);
        repeat (4) step();

        // Back-to-back at minimum gap: next start in the strobe cycle
        PRESCALE = 6'd8; step();
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 6, 3'b001, 1'b1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 8, 3'b001, 1'b1);
        repeat (4) step();

        // Reset during data bit 4 (line stays high afterwards: 0xF0)
        fork
            send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 8, 3'b000, 1'b0);
            begin
                repeat (42) step();
                check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
                RST = 1'b0;
                step();
                check("post_rst_busy", {31'd0, BUSY}, 32'd0);
                check("post_rst_p_data", {24'd0, P_DATA}, 32'd0);
`ifdef UART_RX_ERR_CNT_EN
                check("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
                model_pdata = 8'h00;
                RST = 1'b1;
            end
        join
        repeat (4) step();
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 8, 3'b001, 1'b1);
        repeat (4) step();

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
